nand_op_sequencer: RTL and testbench
====================================

# nand_op_sequencer

Translates high-level NAND operations (page read, page program, block erase, status read) into the ordered instruction words and command/address bytes consumed by the flash bus controller's instruction queue and data FIFO. It sits between the core's operation request port and the flash controller: it builds each ONFI-style command sequence, monitors the R/B# line and polls status after program/erase. One operation is in flight at a time.

## Interface
- BUSY_LOW_WAIT, 16: max cycles to wait for R/B# to fall after a confirm command (tWB window).
- TIMEOUT_CYCLES, 2000000: max cycles R/B# may stay low before a timeout error.
- clk  in  1  system clock (80 MHz).
- rst  in  1  reset, asynchronous, active-low.
- op_valid  in  1  operation request valid.
- op_ready  out  1  sequencer idle, can accept request.
- op_code  in  2  0=READ, 1=PROGRAM, 2=ERASE, 3=STATUS.
- op_row  in  24  row (page/block) address.
- op_col  in  16  column address (READ/PROGRAM only).
- op_len  in  12  data bytes for READ/PROGRAM; 0 = no data phase.
- instr_valid / instr_ready  out / in  1 / 1  instruction word handshake.
- instr_mode  out  4  flash mode: 2=CMD, 3=ADDR, 4=DIN, 5=DOUT.
- instr_count  out  12  repeat count for that mode.
- byte_valid / byte_ready  out / in  1 / 1  command/address byte handshake.
- byte_data  out  8  command or address byte.
- rb_n  in  1  raw flash R/B#, asynchronous.
- status_valid  in  1  status byte returned from DOUT path.
- status_data  in  8  returned status byte.
- done  out  1  one-cycle completion pulse.
- error  out  1  valid with done: status[0] fail or timeout.
- timeout  out  1  valid with done: R/B# timeout.
- status  out  8  last captured status byte; held until next capture.

## Operation
- Sequences (bytes in emit order, address LSB first):
  - READ: CMD 00h; ADDR ×5 (col[7:0], col[15:8], row[7:0], row[15:8], row[23:16]); CMD 30h; busy wait; DOUT op_len (skipped if 0).
  - PROGRAM: CMD 80h; ADDR ×5; DIN op_len (skipped if 0); CMD 10h; busy wait; status poll.
  - ERASE: CMD 60h; ADDR ×3 (row bytes); CMD D0h; busy wait; status poll.
  - STATUS: status poll only.
  - Status poll: CMD 70h; DOUT count 1; wait status_valid; capture status; error = status[0].
- CMD step: one instruction word (mode 2, count 1) and one byte; ADDR step: one word (mode 3, count 3 or 5) then that many bytes; DIN/DOUT steps: one word, no bytes (payload flows on the data path, not through this block).
- Instruction and byte handshakes are independent; a step advances only after all its words and bytes are accepted. valid held and data stable until ready.
- States: IDLE, CMD1, ADDR, DATA, CMD2, BUSY_FALL, BUSY_RISE, STAT_CMD, STAT_DOUT, STAT_WAIT, DONE.
- Busy wait: BUSY_FALL waits for synchronized rb_n=0 up to BUSY_LOW_WAIT cycles, then moves to BUSY_RISE regardless; BUSY_RISE waits for rb_n=1; counter reaching TIMEOUT_CYCLES → DONE with error=1, timeout=1, status poll skipped.
- rb_n passes through a 2-flop synchronizer; only the synchronized value is used.
- Reset mid-operation: return to IDLE immediately, drop all valids, no done pulse; in-flight request discarded.

## Timing
- Reset values: op_ready=1, instr_valid=0, byte_valid=0, instr_mode=0, instr_count=0, byte_data=8'h00, done=0, error=0, timeout=0, status=8'h00.
- op accepted on op_valid&op_ready; op_ready low the next cycle; first instr_valid and byte_valid asserted the cycle after acceptance.
- With ready tied high: one word and one byte per cycle; ADDR ×5 takes 5 cycles.
- status_valid sampled only in STAT_WAIT; ignored elsewhere.
- done/error/timeout asserted for exactly one cycle in DONE; op_ready=1 the following cycle; new op_valid may be accepted that cycle.
- op_* inputs registered at acceptance; later changes ignored.

## Structure
- Shared package nand_pkg: flash mode encodings (CMD=2, ADDR=3, DIN=4, DOUT=5), opcode encoding, NAND command byte constants (00h, 30h, 80h, 10h, 60h, D0h, 70h), state enum.
- Sub-module rb_sync (2-flop synchronizer) is natural; everything else is one FSM with a byte index counter and a 21-bit busy counter.

## Test plan
- READ row=0x012345, col=0x0010, len=2048, ready high, rb_n low 100 cycles -> words {2/1,3/5,2/1,5/2048}; bytes 00,10,00,45,23,01,30; done, error=0.
- PROGRAM len=4, status_data=0x01 -> words {2/1,3/5,4/4,2/1,2/1,5/1}; bytes 80,…,10,70; done with error=1, status=0x01.
- ERASE row=0xABCDEF, rb_n never falls -> bytes 60,EF,CD,AB,D0; BUSY_RISE entered after 16 cycles; status poll runs; error=0 with status 0xE0.
- ERASE with rb_n held low -> done after TIMEOUT_CYCLES, error=1, timeout=1, no 70h byte emitted.
- Random instr_ready/byte_ready stalls on READ -> emitted sequence identical, data stable while valid&!ready.
- rst asserted during ADDR -> all valids 0 next edge, op_ready=1, no done pulse; new STATUS op completes normally.

Source files
------------

// File: rtl/nand_pkg.sv
// Shared encodings for the NAND operation sequencer: flash instruction modes,
// operation codes, ONFI command bytes and the sequencer state set.
package nand_pkg;

    localparam logic [3:0] MODE_CMD  = 4'd2;
    localparam logic [3:0] MODE_ADDR = 4'd3;
    localparam logic [3:0] MODE_DIN  = 4'd4;
    localparam logic [3:0] MODE_DOUT = 4'd5;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_PROGRAM = 2'd1,
        OP_ERASE   = 2'd2,
        OP_STATUS  = 2'd3
    } op_t;

    localparam logic [7:0] NAND_READ_1   = 8'h00;
    localparam logic [7:0] NAND_READ_2   = 8'h30;
    localparam logic [7:0] NAND_PROG_1   = 8'h80;
    localparam logic [7:0] NAND_PROG_2   = 8'h10;
    localparam logic [7:0] NAND_ERASE_1  = 8'h60;
    localparam logic [7:0] NAND_ERASE_2  = 8'hD0;
    localparam logic [7:0] NAND_STATUS   = 8'h70;

    localparam int BUSY_CNT_W = 21;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD1,
        ST_ADDR,
        ST_DATA,
        ST_CMD2,
        ST_BUSY_FALL,
        ST_BUSY_RISE,
        ST_STAT_CMD,
        ST_STAT_DOUT,
        ST_STAT_WAIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/rb_sync.sv
// Two-flop synchronizer for the raw flash R/B# line; idles high (ready).
module rb_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/nand_op_sequencer.sv
// Expands one NAND operation into instruction words and command/address bytes,
// waits on R/B# and polls status after program/erase.
module nand_op_sequencer
    import nand_pkg::*;
#(
    parameter int unsigned BUSY_LOW_WAIT  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [1:0]  op_code,
    input  logic [23:0] op_row,
    input  logic [15:0] op_col,
    input  logic [11:0] op_len,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [3:0]  instr_mode,
    output logic [11:0] instr_count,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic [7:0]  byte_data,
    input  logic        rb_n,
    input  logic        status_valid,
    input  logic [7:0]  status_data,
    output logic        done,
    output logic        error,
    output logic        timeout,
    output logic [7:0]  status
);

    localparam logic [BUSY_CNT_W-1:0] LOW_LAST = BUSY_CNT_W'(BUSY_LOW_WAIT - 1);
    localparam logic [BUSY_CNT_W-1:0] TMO_LAST = BUSY_CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                state, state_nx;
    op_t                   op_q;
    logic [23:0]           row_q;
    logic [15:0]           col_q;
    logic [11:0]           len_q;
    logic [2:0]            idx;
    logic [2:0]            nbytes;
    logic                  has_word;
    logic                  word_sent;
    logic                  instr_fire, byte_fire, step_adv;
    logic [BUSY_CNT_W-1:0] cnt;
    logic                  tmo_hit;
    logic                  err_q, tmo_q;
    logic                  rb_s;

    rb_sync u_rb_sync (
        .clk (clk),
        .rst (rst),
        .d   (rb_n),
        .q   (rb_s)
    );

    function automatic logic [7:0] cmd1_byte(input op_t op);
        case (op)
            OP_READ:    cmd1_byte = NAND_READ_1;
            OP_PROGRAM: cmd1_byte = NAND_PROG_1;
            OP_ERASE:   cmd1_byte = NAND_ERASE_1;
            default:    cmd1_byte = NAND_STATUS;
        endcase
    endfunction

    function automatic logic [7:0] cmd2_byte(input op_t op);
        case (op)
            OP_READ:    cmd2_byte = NAND_READ_2;
            OP_PROGRAM: cmd2_byte = NAND_PROG_2;
            default:    cmd2_byte = NAND_ERASE_2;
        endcase
    endfunction

    // Erase carries only the three row bytes; read/program lead with two column bytes.
    function automatic logic [7:0] addr_byte(input op_t op, input logic [2:0] i,
                                             input logic [15:0] col, input logic [23:0] row);
        logic [2:0] k;
        k = (op == OP_ERASE) ? i + 3'd2 : i;
        case (k)
            3'd0:    addr_byte = col[7:0];
            3'd1:    addr_byte = col[15:8];
            3'd2:    addr_byte = row[7:0];
            3'd3:    addr_byte = row[15:8];
            default: addr_byte = row[23:16];
        endcase
    endfunction

    always_comb begin
        state_nx    = state;
        op_ready    = 1'b0;
        has_word    = 1'b0;
        nbytes      = 3'd0;
        instr_mode  = 4'd0;
        instr_count = 12'd0;
        byte_data   = 8'h00;
        done        = 1'b0;
        error       = 1'b0;
        timeout     = 1'b0;
        tmo_hit     = 1'b0;

        case (state)
            ST_CMD1:      begin has_word = 1'b1; nbytes = 3'd1; instr_mode = MODE_CMD;
                                instr_count = 12'd1; byte_data = cmd1_byte(op_q); end
            ST_ADDR:      begin has_word = 1'b1; nbytes = (op_q == OP_ERASE) ? 3'd3 : 3'd5;
                                instr_mode = MODE_ADDR; instr_count = {9'd0, nbytes};
                                byte_data = addr_byte(op_q, idx, col_q, row_q); end
            ST_DATA:      begin has_word = 1'b1; instr_count = len_q;
                                instr_mode = (op_q == OP_READ) ? MODE_DOUT : MODE_DIN; end
            ST_CMD2:      begin has_word = 1'b1; nbytes = 3'd1; instr_mode = MODE_CMD;
                                instr_count = 12'd1; byte_data = cmd2_byte(op_q); end
            ST_STAT_CMD:  begin has_word = 1'b1; nbytes = 3'd1; instr_mode = MODE_CMD;
                                instr_count = 12'd1; byte_data = NAND_STATUS; end
            ST_STAT_DOUT: begin has_word = 1'b1; instr_mode = MODE_DOUT; instr_count = 12'd1; end
            default: ;
        endcase

        instr_valid = has_word && !word_sent;
        byte_valid  = idx < nbytes;
        instr_fire  = instr_valid && instr_ready;
        byte_fire   = byte_valid && byte_ready;
        step_adv    = has_word && (word_sent || instr_fire)
                      && ((idx == nbytes) || (byte_fire && (idx == nbytes - 3'd1)));

        case (state)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (op_valid)
                    state_nx = (op_t'(op_code) == OP_STATUS) ? ST_STAT_CMD : ST_CMD1;
            end
            ST_CMD1:      if (step_adv) state_nx = ST_ADDR;
            ST_ADDR:      if (step_adv)
                              state_nx = (op_q == OP_PROGRAM && len_q != 12'd0) ? ST_DATA : ST_CMD2;
            ST_DATA:      if (step_adv) state_nx = (op_q == OP_READ) ? ST_DONE : ST_CMD2;
            ST_CMD2:      if (step_adv) state_nx = ST_BUSY_FALL;
            // Leave after the tWB window even if R/B# never dropped.
            ST_BUSY_FALL: if (!rb_s || cnt == LOW_LAST) state_nx = ST_BUSY_RISE;
            ST_BUSY_RISE: begin
                if (rb_s) begin
                    if (op_q == OP_READ)
                        state_nx = (len_q != 12'd0) ? ST_DATA : ST_DONE;
                    else
                        state_nx = ST_STAT_CMD;
                end else if (cnt == TMO_LAST) begin
                    tmo_hit  = 1'b1;
                    state_nx = ST_DONE;
                end
            end
            ST_STAT_CMD:  if (step_adv) state_nx = ST_STAT_DOUT;
            ST_STAT_DOUT: if (step_adv) state_nx = ST_STAT_WAIT;
            ST_STAT_WAIT: if (status_valid) state_nx = ST_DONE;
            ST_DONE: begin
                done     = 1'b1;
                error    = err_q;
                timeout  = tmo_q;
                state_nx = ST_IDLE;
            end
            default:      state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            word_sent <= 1'b0;
            idx       <= 3'd0;
            cnt       <= '0;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
            status    <= 8'h00;
        end else begin
            state <= state_nx;
            if (step_adv) begin
                word_sent <= 1'b0;
                idx       <= 3'd0;
            end else begin
                if (instr_fire) word_sent <= 1'b1;
                if (byte_fire)  idx <= idx + 3'd1;
            end
            if (state_nx != state || (state != ST_BUSY_FALL && state != ST_BUSY_RISE))
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (state == ST_IDLE && op_valid) begin
                err_q <= 1'b0;
                tmo_q <= 1'b0;
            end else if (tmo_hit) begin
                err_q <= 1'b1;
                tmo_q <= 1'b1;
            end else if (state == ST_STAT_WAIT && status_valid) begin
                err_q  <= status_data[0];
                status <= status_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && op_valid) begin
            op_q  <= op_t'(op_code);
            row_q <= op_row;
            col_q <= op_col;
            len_q <= op_len;
        end
    end

endmodule

// File: tb/tb_nand_op_sequencer.sv
// Directed vector bench for nand_op_sequencer: records every accepted word/byte
// and compares against hand-computed sequences, flags and status.
module tb_nand_op_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [1:0]  op_code = 2'd0;
    logic [23:0] op_row = '0;
    logic [15:0] op_col = '0;
    logic [11:0] op_len = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [3:0]  instr_mode;
    logic [11:0] instr_count;
    logic        byte_valid;
    logic        byte_ready = 1'b1;
    logic [7:0]  byte_data;
    logic        rb_n = 1'b1;
    logic        status_valid = 1'b0;
    logic [7:0]  status_data = 8'h00;
    logic        done, error, timeout;
    logic [7:0]  status;

    always #5 clk = ~clk;

    nand_op_sequencer #(.BUSY_LOW_WAIT(16), .TIMEOUT_CYCLES(300)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_row(op_row), .op_col(op_col), .op_len(op_len),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_mode(instr_mode), .instr_count(instr_count),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
        .rb_n(rb_n), .status_valid(status_valid), .status_data(status_data),
        .done(done), .error(error), .timeout(timeout), .status(status)
    );

    typedef struct {
        logic [1:0]        code;
        logic [23:0]       row;
        logic [15:0]       col;
        logic [11:0]       len;
        int                rb_mode;   // 0: low for rb_low cycles, 1: never falls, 2: held low
        int                rb_low;
        bit                stall;
        logic [7:0]        stat;
        int                nw;
        logic [0:5][15:0]  words;
        int                nb;
        logic [0:7][7:0]   bytes;
        int                conf;      // index of the confirm byte that starts the busy wait
        int                gap;       // expected cycles from confirm byte to 70h byte, 0 = skip
        bit                err;
        bit                tmo;
        logic [7:0]        exp_st;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] words_q[$];
    logic [7:0]  bytes_q[$];
    int          bcyc_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cyc, rb_cnt, st_cnt, after, done_cnt, stab;
        bit piv, pbv, first_ok, got_err, got_tmo, rdy_after;
        logic [15:0] pw;
        logic [7:0]  pb;
        logic [31:0] act;
        words_q.delete(); bytes_q.delete(); bcyc_q.delete();
        rb_cnt = -1; st_cnt = -1; after = 0; done_cnt = 0; stab = 0;
        piv = 0; pbv = 0; first_ok = 0; got_err = 0; got_tmo = 0; rdy_after = 0;
        pw = '0; pb = '0;
        @(negedge clk);
        rb_n = (v.rb_mode == 2) ? 1'b0 : 1'b1;
        instr_ready = 1'b1; byte_ready = 1'b1;
        chk({tag, " op_ready_idle"}, op_ready, 1);
        op_valid = 1'b1; op_code = v.code; op_row = v.row; op_col = v.col; op_len = v.len;
        @(negedge clk);
        op_valid = 1'b0; op_code = ~v.code; op_row = ~v.row; op_col = ~v.col; op_len = ~v.len;
        cyc = 0;
        while (cyc < 1000 && after != 1) begin
            if (cyc > 0) @(negedge clk);
            if (cyc == 0) first_ok = instr_valid && byte_valid && !op_ready;
            instr_ready = v.stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            byte_ready  = v.stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (piv && (!instr_valid || {instr_mode, instr_count} != pw)) stab++;
            if (pbv && (!byte_valid || byte_data != pb)) stab++;
            piv = instr_valid && !instr_ready; pw = {instr_mode, instr_count};
            pbv = byte_valid && !byte_ready;   pb = byte_data;
            if (instr_valid && instr_ready) begin
                words_q.push_back({instr_mode, instr_count});
                if ({instr_mode, instr_count} == 16'h5001 && v.code != 2'd0) st_cnt = 2;
            end
            if (byte_valid && byte_ready) begin
                bytes_q.push_back(byte_data);
                bcyc_q.push_back(cyc);
                if (bytes_q.size() == v.conf + 1 && v.rb_mode == 0) rb_cnt = v.rb_low;
            end
            if (done) begin
                done_cnt++; got_err = error; got_tmo = timeout; after = 3;
            end else if (after > 1) begin
                if (after == 3) rdy_after = op_ready;
                after--;
            end
            if (rb_cnt > 0) begin
                rb_n = 1'b0; status_valid = 1'b1; status_data = 8'h5A; rb_cnt--;
            end else if (rb_cnt == 0) begin
                rb_n = 1'b1; status_valid = 1'b0; rb_cnt = -1;
            end
            if (st_cnt > 0) begin
                st_cnt--;
                if (st_cnt == 0) begin status_valid = 1'b1; status_data = v.stat; end
            end else if (st_cnt == 0) begin
                status_valid = 1'b0; st_cnt = -1;
            end
            cyc++;
        end
        rb_n = 1'b1; status_valid = 1'b0; instr_ready = 1'b1; byte_ready = 1'b1;
        chk({tag, " first_valid"}, first_ok, 1);
        chk({tag, " done_pulses"}, done_cnt, 1);
        chk({tag, " word_count"}, words_q.size(), v.nw);
        for (int i = 0; i < v.nw; i++) begin
            act = (i < words_q.size()) ? {16'h0, words_q[i]} : 32'hFFFFFFFF;
            chk($sformatf("%s word%0d", tag, i), act, v.words[i]);
        end
        chk({tag, " byte_count"}, bytes_q.size(), v.nb);
        for (int i = 0; i < v.nb; i++) begin
            act = (i < bytes_q.size()) ? {24'h0, bytes_q[i]} : 32'hFFFFFFFF;
            chk($sformatf("%s byte%0d", tag, i), act, v.bytes[i]);
        end
        if (v.gap > 0) begin
            act = (bcyc_q.size() > v.conf + 1) ? bcyc_q[v.conf + 1] - bcyc_q[v.conf] : 32'hFFFFFFFF;
            chk({tag, " busy_gap"}, act, v.gap);
        end
        chk({tag, " error"}, got_err, v.err);
        chk({tag, " timeout"}, got_tmo, v.tmo);
        chk({tag, " status"}, status, v.exp_st);
        chk({tag, " stable_while_stalled"}, stab, 0);
        chk({tag, " op_ready_after_done"}, rdy_after, 1);
    endtask

    vec_t vt[5];
    vec_t vstat;

    initial begin
        int dn;
        bit reached;
        vt[0] = '{code:2'd0, row:24'h012345, col:16'h0010, len:12'd2048, rb_mode:0, rb_low:100,
                  stall:0, stat:8'h00, nw:4,
                  words:{16'h2001, 16'h3005, 16'h2001, 16'h5800, 16'h0, 16'h0},
                  nb:7, bytes:{8'h00, 8'h10, 8'h00, 8'h45, 8'h23, 8'h01, 8'h30, 8'h00},
                  conf:6, gap:0, err:0, tmo:0, exp_st:8'h00};
        vt[1] = '{code:2'd1, row:24'h030201, col:16'h0504, len:12'd4, rb_mode:0, rb_low:30,
                  stall:0, stat:8'h01, nw:6,
                  words:{16'h2001, 16'h3005, 16'h4004, 16'h2001, 16'h2001, 16'h5001},
                  nb:8, bytes:{8'h80, 8'h04, 8'h05, 8'h01, 8'h02, 8'h03, 8'h10, 8'h70},
                  conf:6, gap:0, err:1, tmo:0, exp_st:8'h01};
        vt[2] = '{code:2'd2, row:24'hABCDEF, col:16'h1111, len:12'd7, rb_mode:1, rb_low:0,
                  stall:0, stat:8'hE0, nw:5,
                  words:{16'h2001, 16'h3003, 16'h2001, 16'h2001, 16'h5001, 16'h0},
                  nb:6, bytes:{8'h60, 8'hEF, 8'hCD, 8'hAB, 8'hD0, 8'h70, 8'h00, 8'h00},
                  conf:4, gap:18, err:0, tmo:0, exp_st:8'hE0};
        vt[3] = '{code:2'd2, row:24'hABCDEF, col:16'h0000, len:12'd0, rb_mode:2, rb_low:0,
                  stall:0, stat:8'h00, nw:3,
                  words:{16'h2001, 16'h3003, 16'h2001, 16'h0, 16'h0, 16'h0},
                  nb:5, bytes:{8'h60, 8'hEF, 8'hCD, 8'hAB, 8'hD0, 8'h00, 8'h00, 8'h00},
                  conf:4, gap:0, err:1, tmo:1, exp_st:8'hE0};
        vt[4] = '{code:2'd0, row:24'h00FEDC, col:16'hBA98, len:12'd0, rb_mode:0, rb_low:20,
                  stall:1, stat:8'h00, nw:3,
                  words:{16'h2001, 16'h3005, 16'h2001, 16'h0, 16'h0, 16'h0},
                  nb:7, bytes:{8'h00, 8'h98, 8'hBA, 8'hDC, 8'hFE, 8'h00, 8'h30, 8'h00},
                  conf:6, gap:0, err:0, tmo:0, exp_st:8'hE0};
        vstat = '{code:2'd3, row:24'h0, col:16'h0, len:12'd0, rb_mode:1, rb_low:0,
                  stall:0, stat:8'hC0, nw:2,
                  words:{16'h2001, 16'h5001, 16'h0, 16'h0, 16'h0, 16'h0},
                  nb:1, bytes:{8'h70, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  conf:99, gap:0, err:0, tmo:0, exp_st:8'hC0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst op_ready", op_ready, 1);
        chk("rst instr_valid", instr_valid, 0);
        chk("rst byte_valid", byte_valid, 0);
        chk("rst instr_mode", instr_mode, 0);
        chk("rst instr_count", instr_count, 0);
        chk("rst byte_data", byte_data, 0);
        chk("rst done_error_timeout", {done, error, timeout}, 0);
        chk("rst status", status, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Reset in the middle of the address phase
        @(negedge clk);
        op_valid = 1'b1; op_code = 2'd0; op_row = 24'h012345; op_col = 16'h0010; op_len = 12'd16;
        @(negedge clk);
        op_valid = 1'b0;
        reached = 0;
        for (int i = 0; i < 10 && !reached; i++) begin
            if (instr_mode == 4'd3) reached = 1;
            else @(negedge clk);
        end
        chk("midrst reached_addr", reached, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst instr_valid", instr_valid, 0);
        chk("midrst byte_valid", byte_valid, 0);
        chk("midrst op_ready", op_ready, 1);
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("midrst no_done", dn, 0);
        chk("midrst status_cleared", status, 0);
        run_vec(vstat, "status_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
